// File: rtl/packet_gen.sv
// Telemetry packet generator: one {data, ts, id} packet per PERIOD clocks,
// channels served round-robin, offered on a valid/ready handshake.
module packet_gen #(
    parameter int                 DATA_W     = 16,
    parameter int                 TS_W       = 24,
    parameter int                 ID_W       = 8,
    parameter int                 NUM_CH     = 4,
    parameter logic [ID_W-1:0]    ID_BASE    = 8'h47,
    parameter logic [DATA_W-1:0]  DATA_CONST = 16'h0027,
    parameter int                 PERIOD     = 1000,
    localparam int                CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int                PKT_W      = DATA_W + TS_W + ID_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             mode,
    input  logic             pkt_ready,
    output logic             pkt_valid,
    output logic [PKT_W-1:0] pkt_data,
    output logic [CH_W-1:0]  pkt_ch,
    output logic [7:0]       drop_cnt
);

    localparam int PCNT_W = $clog2(PERIOD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        OFFER = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [TS_W-1:0]     ts_r;
    logic [PCNT_W-1:0]   pcnt_r;
    logic [CH_W-1:0]     ptr_r;
    logic [DATA_W-1:0]   seq_r [NUM_CH];

    logic                fire_s;
    logic                accept_s;
    logic                latch_s;
    logic                drop_s;
    logic [CH_W-1:0]     ptr_inc_s;
    logic [CH_W-1:0]     latch_ch_s;
    logic [DATA_W-1:0]   seq_sel_s;
    logic [DATA_W-1:0]   data_s;
    logic [ID_W-1:0]     id_s;

    assign fire_s    = enable & (pcnt_r == PCNT_W'(PERIOD - 1));
    assign ptr_inc_s = (ptr_r == CH_W'(NUM_CH - 1)) ? {CH_W{1'b0}} : ptr_r + CH_W'(1'b1);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and handshake/latch decisions.
    always_comb begin
        state_s    = state_r;
        accept_s   = 1'b0;
        latch_s    = 1'b0;
        drop_s     = 1'b0;
        latch_ch_s = ptr_r;
        case (state_r)
            IDLE: begin
                if (enable) begin
                    state_s = ARMED;
                end else begin
                    state_s = IDLE;
                end
            end
            ARMED: begin
                if (fire_s) begin
                    latch_s = 1'b1;
                    state_s = OFFER;
                end else if (!enable) begin
                    state_s = IDLE;
                end else begin
                    state_s = ARMED;
                end
            end
            OFFER: begin
                if (pkt_ready) begin
                    accept_s = 1'b1;
                    if (fire_s) begin
                        // Back-to-back: the next channel's packet replaces the accepted one.
                        latch_s    = 1'b1;
                        latch_ch_s = ptr_inc_s;
                        state_s    = OFFER;
                    end else if (enable) begin
                        state_s = ARMED;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    if (fire_s) begin
                        drop_s = 1'b1;
                    end else begin
                        drop_s = 1'b0;
                    end
                    state_s = OFFER;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Payload selection; the same-cycle accept increment is visible when the channel repeats.
    always_comb begin
        seq_sel_s = seq_r[latch_ch_s];
        if (accept_s && mode && (latch_ch_s == ptr_r)) begin
            seq_sel_s = seq_r[latch_ch_s] + DATA_W'(1'b1);
        end else begin
            seq_sel_s = seq_r[latch_ch_s];
        end
        if (mode) begin
            data_s = seq_sel_s;
        end else begin
            data_s = DATA_CONST;
        end
        id_s = ID_BASE + ID_W'(latch_ch_s);
    end

    // Timebase, channel rotation, sequence counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_r      <= {TS_W{1'b0}};
            pcnt_r    <= {PCNT_W{1'b0}};
            ptr_r     <= {CH_W{1'b0}};
            pkt_valid <= 1'b0;
            pkt_data  <= {PKT_W{1'b0}};
            pkt_ch    <= {CH_W{1'b0}};
            drop_cnt  <= 8'h00;
            for (int i = 0; i < NUM_CH; i++) begin
                seq_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (enable) begin
                ts_r <= ts_r + TS_W'(1'b1);
            end
            if (!enable || fire_s) begin
                pcnt_r <= {PCNT_W{1'b0}};
            end else begin
                pcnt_r <= pcnt_r + PCNT_W'(1'b1);
            end
            if (accept_s) begin
                ptr_r <= ptr_inc_s;
                if (mode) begin
                    seq_r[ptr_r] <= seq_r[ptr_r] + DATA_W'(1'b1);
                end
            end
            if (latch_s) begin
                pkt_data <= {data_s, ts_r, id_s};
                pkt_ch   <= latch_ch_s;
            end
            if (drop_s && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
            pkt_valid <= (state_s == OFFER);
        end
    end

endmodule

// File: tb/tb_packet_gen.sv
// Directed bench for packet_gen (PERIOD=4, NUM_CH=4) with an expected-packet scoreboard.
module tb_packet_gen;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        mode;
    logic        pkt_ready;
    logic        pkt_valid;
    logic [47:0] pkt_data;
    logic [1:0]  pkt_ch;
    logic [7:0]  drop_cnt;

    int vectors;
    int miscompares;

    typedef struct packed {
        logic [47:0] data;
        logic [1:0]  ch;
    } exp_t;

    exp_t sb[$];

    packet_gen #(.PERIOD(4), .NUM_CH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .mode      (mode),
        .pkt_ready (pkt_ready),
        .pkt_valid (pkt_valid),
        .pkt_data  (pkt_data),
        .pkt_ch    (pkt_ch),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] d, input logic [23:0] ts, input logic [7:0] id,
                        input logic [1:0] ch);
        exp_t e;
        e.data = {d, ts, id};
        e.ch   = ch;
        sb.push_back(e);
    endtask

    // Waits (bounded) for a handshake, then checks it against the scoreboard head.
    task automatic wait_accept(input string tag);
        bit   done;
        exp_t e;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (pkt_valid && pkt_ready) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $error("FAIL %s: unexpected packet observed=%0h expected=none", tag, pkt_data);
                end else begin
                    e = sb.pop_front();
                    chk({tag, "_data"}, 64'(pkt_data), 64'(e.data));
                    chk({tag, "_ch"}, 64'(pkt_ch), 64'(e.ch));
                end
                done = 1'b1;
            end
            tick();
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: timeout observed=no_handshake expected=handshake", tag);
        end
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        enable = 1'b0;
        ticks(2);
        rst = 1'b0;
        sb.delete();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        enable      = 1'b0;
        mode        = 1'b0;
        pkt_ready   = 1'b0;
        ticks(2);
        chk("rst_valid", 64'(pkt_valid), 64'(1'b0));
        chk("rst_data", 64'(pkt_data), 64'(48'h0));
        chk("rst_ch", 64'(pkt_ch), 64'(2'd0));
        chk("rst_drop", 64'(drop_cnt), 64'(8'h00));

        // Constant payload, first two packets.
        do_reset();
        mode = 1'b0; pkt_ready = 1'b1; enable = 1'b1;
        ticks(3);
        chk("t1_valid_k3", 64'(pkt_valid), 64'(1'b0));
        tick();
        chk("t1_valid_k4", 64'(pkt_valid), 64'(1'b1));
        push(16'h0027, 24'd3, 8'h47, 2'd0);
        push(16'h0027, 24'd7, 8'h48, 2'd1);
        wait_accept("t1_p0");
        wait_accept("t1_p1");

        // Sequence payload and ID rotation.
        do_reset();
        mode = 1'b1; pkt_ready = 1'b1; enable = 1'b1;
        push(16'd0, 24'd3, 8'h47, 2'd0);
        push(16'd0, 24'd7, 8'h48, 2'd1);
        push(16'd0, 24'd11, 8'h49, 2'd2);
        push(16'd0, 24'd15, 8'h4A, 2'd3);
        push(16'd1, 24'd19, 8'h47, 2'd0);
        for (int i = 0; i < 5; i++) wait_accept("t2_seq");

        // Back-pressure: two missed slots, held packet unchanged.
        do_reset();
        mode = 1'b0; pkt_ready = 1'b0; enable = 1'b1;
        ticks(4);
        for (int i = 0; i < 10; i++) begin
            chk("t3_hold_valid", 64'(pkt_valid), 64'(1'b1));
            chk("t3_hold_data", 64'(pkt_data), 64'({16'h0027, 24'd3, 8'h47}));
            tick();
        end
        chk("t3_drop", 64'(drop_cnt), 64'(8'd2));
        pkt_ready = 1'b1;
        push(16'h0027, 24'd3, 8'h47, 2'd0);
        push(16'h0027, 24'd15, 8'h48, 2'd1);
        wait_accept("t3_p0");
        wait_accept("t3_p1");

        // drop_cnt saturation.
        do_reset();
        mode = 1'b0; pkt_ready = 1'b0; enable = 1'b1;
        ticks(1020);
        chk("t4_drop_fe", 64'(drop_cnt), 64'(8'hFE));
        ticks(184);
        chk("t4_drop_ff", 64'(drop_cnt), 64'(8'hFF));
        chk("t4_ch", 64'(pkt_ch), 64'(2'd0));
        pkt_ready = 1'b1;
        push(16'h0027, 24'd3, 8'h47, 2'd0);
        wait_accept("t4_p0");

        // Back-to-back: ready rises on a fire cycle in OFFER.
        do_reset();
        mode = 1'b1; pkt_ready = 1'b0; enable = 1'b1;
        ticks(7);
        pkt_ready = 1'b1;
        push(16'd0, 24'd3, 8'h47, 2'd0);
        push(16'd0, 24'd7, 8'h48, 2'd1);
        wait_accept("t5_p0");
        chk("t5_valid_kept", 64'(pkt_valid), 64'(1'b1));
        chk("t5_no_drop", 64'(drop_cnt), 64'(8'd0));
        wait_accept("t5_p1");

        // enable falls while offering: packet held, ts frozen.
        do_reset();
        mode = 1'b0; pkt_ready = 1'b0; enable = 1'b1;
        ticks(4);
        enable = 1'b0;
        ticks(6);
        chk("t6_hold_valid", 64'(pkt_valid), 64'(1'b1));
        chk("t6_no_drop", 64'(drop_cnt), 64'(8'd0));
        pkt_ready = 1'b1;
        push(16'h0027, 24'd3, 8'h47, 2'd0);
        wait_accept("t6_p0");
        for (int i = 0; i < 4; i++) begin
            chk("t6_idle_valid", 64'(pkt_valid), 64'(1'b0));
            tick();
        end
        enable = 1'b1;
        push(16'h0027, 24'd7, 8'h48, 2'd1);
        wait_accept("t6_p1");

        // Reset in the middle of an offered packet.
        do_reset();
        mode = 1'b0; pkt_ready = 1'b0; enable = 1'b1;
        ticks(8);
        chk("t7_drop_pre", 64'(drop_cnt), 64'(8'd1));
        rst = 1'b1;
        tick();
        chk("t7_valid", 64'(pkt_valid), 64'(1'b0));
        chk("t7_data", 64'(pkt_data), 64'(48'h0));
        chk("t7_drop", 64'(drop_cnt), 64'(8'd0));
        rst = 1'b0;
        enable = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
